// File: rtl/tfp2fix.sv
// -----------------------------------------------------------------------------
// tfp2fix - trivial float-point to fixed-point expander.
//
// Decodes a tfp word {mantissa, exponent} into fix = extend(mantissa) << exponent.
// The left shift is a logarithmic barrel shifter of EXP_WIDTH stages. Stage k
// shifts by 2**k when exponent bit k is set. The exponent travels alongside the
// partial result. Pipeline registers are placed as follows:
//   - one input register, when PIPELINE > 0;
//   - PIPELINE-1 further registers, placed after the highest-index stages.
// Every register advances only when clkena is high. rst clears every register
// and takes priority over clkena. With PIPELINE = 0 the block is purely
// combinational.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   clkena     in   clock enable; low holds all state
//   tfp_valid  in   input word qualifier
//   tfp_data   in   [TFP_WIDTH-1:EXP_WIDTH] mantissa, [EXP_WIDTH-1:0] exponent
//   fix_valid  out  output qualifier aligned with fix_data
//   fix_data   out  expanded fixed-point value, FIX_WIDTH = M + MAX_EXP
// -----------------------------------------------------------------------------
module tfp2fix #(
    parameter int TFP_WIDTH = 8,
    parameter int EXP_WIDTH = 3,
    parameter int FIX_WIDTH = TFP_WIDTH - EXP_WIDTH + 2**EXP_WIDTH - 1,
    parameter     SIGNREP   = "SIGNED",
    parameter int PIPELINE  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clkena,
    input  logic                 tfp_valid,
    input  logic [TFP_WIDTH-1:0] tfp_data,
    output logic                 fix_valid,
    output logic [FIX_WIDTH-1:0] fix_data
);

    localparam int M         = TFP_WIDTH - EXP_WIDTH;
    localparam bit IS_SIGNED = (SIGNREP == "SIGNED");
    // A register follows shift stage k when k >= FIRST_REG.
    localparam int FIRST_REG = EXP_WIDTH + 1 - PIPELINE;

    function automatic logic [FIX_WIDTH-1:0] extend(input logic signed [M-1:0] mant);
        if (IS_SIGNED)
            return {{(FIX_WIDTH-M){mant[M-1]}}, mant};
        else
            return {{(FIX_WIDTH-M){1'b0}}, mant};
    endfunction

    logic [TFP_WIDTH-1:0] w_in_data;
    logic                 w_in_vld;

    // Partial result, remaining exponent and valid at the input of each stage.
    // Index EXP_WIDTH is the shifter output.
    logic [FIX_WIDTH-1:0] w_d [0:EXP_WIDTH];
    logic [EXP_WIDTH-1:0] w_e [0:EXP_WIDTH];
    logic                 w_v [0:EXP_WIDTH];

    // ---- input register stage ----
    generate
        if (PIPELINE > 0) begin : g_in_reg
            logic [TFP_WIDTH-1:0] r_data_p0;
            logic                 r_vld_p0;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data_p0 <= '0;
                    r_vld_p0  <= 1'b0;
                end else if (clkena) begin
                    r_data_p0 <= tfp_data;
                    r_vld_p0  <= tfp_valid;
                end
            end

            assign w_in_data = r_data_p0;
            assign w_in_vld  = r_vld_p0;
        end else begin : g_in_comb
            assign w_in_data = tfp_data;
            assign w_in_vld  = tfp_valid;
        end
    endgenerate

    assign w_d[0] = extend(w_in_data[TFP_WIDTH-1:EXP_WIDTH]);
    assign w_e[0] = w_in_data[EXP_WIDTH-1:0];
    assign w_v[0] = w_in_vld;

    // ---- shift stages, each optionally followed by a register ----
    generate
        for (genvar k = 0; k < EXP_WIDTH; k++) begin : g_stage
            logic [FIX_WIDTH-1:0] w_sh;

            assign w_sh = w_e[k][k] ? (w_d[k] << (2**k)) : w_d[k];

            if (k >= FIRST_REG) begin : g_reg
                logic [FIX_WIDTH-1:0] r_d_pk;
                logic [EXP_WIDTH-1:0] r_e_pk;
                logic                 r_vld_pk;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_d_pk   <= '0;
                        r_e_pk   <= '0;
                        r_vld_pk <= 1'b0;
                    end else if (clkena) begin
                        r_d_pk   <= w_sh;
                        r_e_pk   <= w_e[k];
                        r_vld_pk <= w_v[k];
                    end
                end

                assign w_d[k+1] = r_d_pk;
                assign w_e[k+1] = r_e_pk;
                assign w_v[k+1] = r_vld_pk;
            end else begin : g_comb
                assign w_d[k+1] = w_sh;
                assign w_e[k+1] = w_e[k];
                assign w_v[k+1] = w_v[k];
            end
        end
    endgenerate

    // ---- output ----
    assign fix_data  = w_d[EXP_WIDTH];
    assign fix_valid = w_v[EXP_WIDTH];

endmodule

// File: tb/tb_tfp2fix.sv
// -----------------------------------------------------------------------------
// tb_tfp2fix - self-checking bench for tfp2fix.
//
// Six instances share one stimulus stream:
//   - indices 0..4 are SIGNED with PIPELINE = 0..4;
//   - index 5 is UNSIGNED with PIPELINE = 2.
// Each output is checked in two ways:
//   - a scoreboard monitor pushes expected words and their due enabled-cycle
//     count, and checks every output, stall hold and reset clear;
//   - the test tasks add their own directed comparisons.
// -----------------------------------------------------------------------------
module tb_tfp2fix;

    localparam int NI = 6;
    localparam int LAT [NI] = '{0, 1, 2, 3, 4, 2};

    localparam logic [7:0]  VEC_IN [6] = '{8'h5B, 8'hAF, 8'hA8, 8'h87, 8'hFF, 8'h08};
    localparam logic [11:0] VEC_S  [6] = '{12'h058, 12'hA80, 12'hFF5, 12'h800, 12'hF80, 12'h001};
    localparam logic [11:0] VEC_U  [6] = '{12'h058, 12'hA80, 12'h015, 12'h800, 12'hF80, 12'h001};

    typedef struct {
        logic [11:0] d;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clkena = 1'b0;
    logic        tfp_valid = 1'b0;
    logic [7:0]  tfp_data = 8'h00;
    logic [11:0] fd [NI];
    logic        fv [NI];

    exp_t        sb [NI][$];
    int          n_pop [NI];
    bit          last_v [NI];
    logic [11:0] last_d [NI];
    int          ecnt = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    tfp2fix #(.PIPELINE(0)) u_p0 (.clk(clk), .rst(rst), .clkena(clkena), .tfp_valid(tfp_valid),
                                  .tfp_data(tfp_data), .fix_valid(fv[0]), .fix_data(fd[0]));
    tfp2fix #(.PIPELINE(1)) u_p1 (.clk(clk), .rst(rst), .clkena(clkena), .tfp_valid(tfp_valid),
                                  .tfp_data(tfp_data), .fix_valid(fv[1]), .fix_data(fd[1]));
    tfp2fix #(.PIPELINE(2)) u_p2 (.clk(clk), .rst(rst), .clkena(clkena), .tfp_valid(tfp_valid),
                                  .tfp_data(tfp_data), .fix_valid(fv[2]), .fix_data(fd[2]));
    tfp2fix #(.PIPELINE(3)) u_p3 (.clk(clk), .rst(rst), .clkena(clkena), .tfp_valid(tfp_valid),
                                  .tfp_data(tfp_data), .fix_valid(fv[3]), .fix_data(fd[3]));
    tfp2fix #(.PIPELINE(4)) u_p4 (.clk(clk), .rst(rst), .clkena(clkena), .tfp_valid(tfp_valid),
                                  .tfp_data(tfp_data), .fix_valid(fv[4]), .fix_data(fd[4]));
    tfp2fix #(.SIGNREP("UNSIGNED"), .PIPELINE(2)) u_u2 (.clk(clk), .rst(rst), .clkena(clkena),
                                  .tfp_valid(tfp_valid), .tfp_data(tfp_data),
                                  .fix_valid(fv[5]), .fix_data(fd[5]));

    // Reference: integer value of the mantissa times 2**exponent, kept to 12 bits.
    function automatic logic [11:0] ref_fix(input logic [7:0] t, input bit sgn);
        int m;
        int r;
        m = sgn ? int'($signed(t[7:3])) : int'(t[7:3]);
        r = m * (1 << t[2:0]);
        return r[11:0];
    endfunction

    // Exact encoder: smallest exponent e with x = m * 2**e and m a 5-bit signed value.
    function automatic bit encode(input int x, output logic [7:0] t);
        t = 8'h00;
        for (int e = 0; e < 8; e++) begin
            int m;
            m = x >>> e;
            if ((x & ((1 << e) - 1)) == 0 && m >= -16 && m <= 15) begin
                t = {m[4:0], 3'(e)};
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor: inputs sampled on the edge, outputs checked 1 time unit later.
    initial begin : monitor
        bit         en, rs, vin;
        logic [7:0] din;
        exp_t       e;
        forever begin
            @(posedge clk);
            en  = clkena;
            rs  = rst;
            vin = tfp_valid;
            din = tfp_data;
            if (!rs && en) ecnt++;
            for (int i = 0; i < NI; i++) begin
                if (LAT[i] == 0) begin
                    if (vin) sb[i].push_back('{ref_fix(din, i != 5), ecnt});
                end else if (rs) begin
                    sb[i].delete();
                end else if (en && vin) begin
                    sb[i].push_back('{ref_fix(din, i != 5), ecnt + LAT[i] - 1});
                end
            end
            #1;
            for (int i = 0; i < NI; i++) begin
                if (LAT[i] != 0 && rs) begin
                    n_cmp++;
                    if (fv[i] !== 1'b0 || fd[i] !== 12'h000) begin
                        n_fail++;
                        $display("FAIL reset_clear inst%0d: got v=%b d=%h, want v=0 d=000", i, fv[i], fd[i]);
                    end
                    last_v[i] = 1'b0;
                end else if (LAT[i] != 0 && !en) begin
                    n_cmp++;
                    if (fv[i] !== last_v[i] || (last_v[i] && fd[i] !== last_d[i])) begin
                        n_fail++;
                        $display("FAIL stall_hold inst%0d: got v=%b d=%h, want v=%b d=%h",
                                 i, fv[i], fd[i], last_v[i], last_d[i]);
                    end
                end else if (fv[i] === 1'b1) begin
                    n_cmp++;
                    if (sb[i].size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_out inst%0d: got d=%h, want no valid output", i, fd[i]);
                        last_v[i] = 1'b0;
                    end else begin
                        e = sb[i].pop_front();
                        n_pop[i]++;
                        if (fd[i] !== e.d || ecnt != e.due) begin
                            n_fail++;
                            $display("FAIL data_latency inst%0d: got d=%h at cyc %0d, want d=%h at cyc %0d",
                                     i, fd[i], ecnt, e.d, e.due);
                        end
                        last_v[i] = 1'b1;
                        last_d[i] = e.d;
                    end
                end else begin
                    last_v[i] = 1'b0;
                    if (fv[i] !== 1'b0 || (sb[i].size() > 0 && sb[i][0].due <= ecnt)) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL missing_out inst%0d: got v=%b, want a valid word", i, fv[i]);
                        if (sb[i].size() > 0) void'(sb[i].pop_front());
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; clkena = 1'b0; tfp_valid = 1'b0; tfp_data = 8'h00;
        tick();
        tick();
        for (int i = 1; i < NI; i++) begin
            n_cmp++;
            if (fv[i] !== 1'b0 || fd[i] !== 12'h000) begin
                n_fail++;
                $display("FAIL test_reset inst%0d: got v=%b d=%h, want v=0 d=000", i, fv[i], fd[i]);
            end
        end
        rst = 1'b0; clkena = 1'b1;
        tick();
    endtask

    task automatic test_vectors();
        clkena = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            if (k <= 6) begin
                tfp_data = VEC_IN[k-1]; tfp_valid = 1'b1;
            end else begin
                tfp_valid = 1'b0;
            end
            tick();
            if (k >= 2) begin
                n_cmp++;
                if (fv[2] !== 1'b1 || fd[2] !== VEC_S[k-2]) begin
                    n_fail++;
                    $display("FAIL vec_signed %0d: got v=%b d=%h, want v=1 d=%h", k-2, fv[2], fd[2], VEC_S[k-2]);
                end
                n_cmp++;
                if (fv[5] !== 1'b1 || fd[5] !== VEC_U[k-2]) begin
                    n_fail++;
                    $display("FAIL vec_unsigned %0d: got v=%b d=%h, want v=1 d=%h", k-2, fv[5], fd[5], VEC_U[k-2]);
                end
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_stream_stalls();
        int base [NI];
        int got;
        for (int i = 0; i < NI; i++) base[i] = n_pop[i];
        for (int w = 0; w < 10; w++) begin
            tfp_data = 8'(($urandom_range(0, 255)));
            tfp_valid = 1'b1;
            for (int t = 0; t < 16; t++) begin
                clkena = (t == 15) ? 1'b1 : 1'($urandom_range(0, 1));
                tick();
                if (clkena) break;
            end
        end
        tfp_valid = 1'b0;
        got = 0;
        for (int t = 0; t < 64 && got < 6; t++) begin
            clkena = 1'($urandom_range(0, 1));
            tick();
            if (clkena) got++;
        end
        clkena = 1'b1;
        tick();
        for (int i = 1; i < NI; i++) begin
            n_cmp++;
            if (n_pop[i] - base[i] != 10) begin
                n_fail++;
                $display("FAIL stream_count inst%0d: got %0d words, want 10", i, n_pop[i] - base[i]);
            end
        end
    endtask

    task automatic test_reset_inflight();
        int base [NI];
        clkena = 1'b1;
        tfp_data = 8'h5B; tfp_valid = 1'b1;
        tick();
        tfp_data = 8'hAF;
        tick();
        tfp_valid = 1'b0; clkena = 1'b0; rst = 1'b1;
        tick();
        for (int i = 1; i < NI; i++) begin
            n_cmp++;
            if (fv[i] !== 1'b0 || fd[i] !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_inflight inst%0d: got v=%b d=%h, want v=0 d=000", i, fv[i], fd[i]);
            end
        end
        rst = 1'b0; clkena = 1'b1;
        for (int i = 0; i < NI; i++) base[i] = n_pop[i];
        repeat (6) tick();
        for (int i = 1; i < NI; i++) begin
            n_cmp++;
            if (n_pop[i] != base[i]) begin
                n_fail++;
                $display("FAIL discarded_words inst%0d: got %0d emitted, want 0", i, n_pop[i] - base[i]);
            end
        end
        tfp_data = 8'h87; tfp_valid = 1'b1;
        tick();
        tfp_valid = 1'b0;
        repeat (5) tick();
        for (int i = 1; i < NI; i++) begin
            n_cmp++;
            if (n_pop[i] - base[i] != 1) begin
                n_fail++;
                $display("FAIL post_reset_word inst%0d: got %0d emitted, want 1", i, n_pop[i] - base[i]);
            end
        end
    endtask

    task automatic test_sweep();
        int base [NI];
        for (int i = 0; i < NI; i++) base[i] = n_pop[i];
        clkena = 1'b1;
        for (int v = 0; v < 256; v++) begin
            tfp_data = 8'(v); tfp_valid = 1'b1;
            tick();
        end
        tfp_valid = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (n_pop[i] - base[i] != 256) begin
                n_fail++;
                $display("FAIL sweep_count inst%0d: got %0d words, want 256", i, n_pop[i] - base[i]);
            end
        end
    endtask

    task automatic test_roundtrip();
        logic [7:0] t;
        int         n_rep;
        n_rep = 0;
        clkena = 1'b1;
        for (int x = -2048; x < 2048; x++) begin
            if (encode(x, t)) begin
                n_rep++;
                tfp_data = t; tfp_valid = 1'b1;
                #1;
                n_cmp++;
                if (fd[0] !== 12'(x)) begin
                    n_fail++;
                    $display("FAIL roundtrip x=%h: got %h, want %h", 12'(x), fd[0], 12'(x));
                end
                tick();
            end
        end
        tfp_valid = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if (n_rep < 100) begin
            n_fail++;
            $display("FAIL roundtrip_coverage: got %0d representable values, want at least 100", n_rep);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin : main
        for (int i = 0; i < NI; i++) begin
            n_pop[i]  = 0;
            last_v[i] = 1'b0;
            last_d[i] = 12'h000;
        end
        test_reset();
        test_vectors();
        test_stream_stalls();
        test_reset_inflight();
        test_sweep();
        test_roundtrip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
